riscv_trace_buffer: RTL
=======================

Name: riscv_trace_buffer

Overview:
Hardware retirement-trace capture for the pipelined RISC-V core. It records PC, instruction, destination register and write-enable of each valid instruction into a parametrised circular buffer. Arming and a PC-match trigger control the capture, followed by a configurable post-trigger window. The frozen trace is then drained over a valid/ready read port. It sits beside the core top and taps the decode/writeback signals.

Parameters:
DW, 32, data/PC/instruction width
REGW, 5, register index width
DEPTH, 16, trace entries (power of two, >=2)
PTRW, $clog2(DEPTH), pointer width
POST_TRIG, 8, entries captured after the trigger entry (0..DEPTH-1)
RECORD_ALL, 1, 1: record every valid instruction; 0: record only those with reg_write_i=1

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous active-high reset
valid_i  in  1  instruction sample valid this cycle
pc_i  in  DW  instruction PC
instr_i  in  DW  instruction word
rd_i  in  REGW  destination register
reg_write_i  in  1  register write enable
arm_i  in  1  clear buffer and start recording
abort_i  in  1  force stop, freeze for readout
trig_en_i  in  1  1: trigger on PC match; 0: trigger on first recorded entry
trig_pc_i  in  DW  trigger PC
rd_ready_i  in  1  reader accepts entry
rd_valid_o  out  1  entry available
rd_pc_o  out  DW  oldest entry PC
rd_instr_o  out  DW  oldest entry instruction
rd_rd_o  out  REGW  oldest entry rd
rd_we_o  out  1  oldest entry reg_write
count_o  out  PTRW+1  stored entries
state_o  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
overflow_o  out  1  sticky: an entry was overwritten since arm

Behaviour:
- Reset (async, rst_i=1): state IDLE, wr_ptr=rd_ptr=0, count_o=0, overflow_o=0, post counter 0. All rd_* outputs 0. Memory is not reset.
- Record event: valid_i && (RECORD_ALL || reg_write_i) while in ARMED or CAPTURE.
- Write: entry goes to mem[wr_ptr], wr_ptr++ (wraps mod DEPTH).
  - If count<DEPTH: count++.
  - Else: rd_ptr++ (oldest dropped) and overflow_o set.
- IDLE: no recording, rd_valid_o=0. arm_i -> ARMED.
- ARMED: records each event.
  - Trigger = event && (!trig_en_i || pc_i==trig_pc_i).
  - On trigger the entry is written and post counter loads POST_TRIG.
  - Next state is CAPTURE, or DONE if POST_TRIG==0.
- CAPTURE: each event is written and the post counter decrements. The write that brings it to 0 moves to DONE on the same edge. Overwrite rules still apply.
- DONE: no recording.
  - rd_valid_o = (count_o!=0).
  - rd_* show mem[rd_ptr] combinationally, and are 0 when rd_valid_o=0.
  - Pop on rd_valid_o && rd_ready_i: rd_ptr++, count--.
  - arm_i -> ARMED.
- arm_i (from IDLE or DONE only): clears pointers, count, overflow and post counter on the same edge. No recording happens on that arming edge. arm_i in ARMED or CAPTURE is ignored.
- abort_i from any state except IDLE -> DONE; stored entries are kept. abort_i in IDLE is ignored. abort_i has priority over arm_i and over a same-cycle record event (that event is discarded).
- Latency: an entry written at edge N can be read once state is DONE. rd_valid_o is registered state plus combinational count, with no extra delay.
- PC comparison is full DW-bit equality. count_o saturates at DEPTH and never exceeds it.

Test Plan:
1. Reset, then arm, trig_en_i=0, RECORD_ALL=1; feed valid PCs 0x00,0x04,... with instr 0x00400193 -> trigger at 0x00, DONE after the 9th entry (PC 0x20). count_o=9, overflow_o=0. Readout gives PCs 0x00..0x20 in order, then rd_valid_o=0.
2. Arm, trig_en_i=1, trig_pc_i=0x40; feed 25 consecutive PCs 0x00..0x60 -> state CAPTURE after 0x40, DONE after 0x60. count_o=16, overflow_o=1. Readout gives 0x24..0x60.
3. RECORD_ALL=0: alternate reg_write_i 1/0 over 10 valid cycles with trig_en_i=0 -> only the 5 write entries are stored. POST_TRIG=8 is not reached; abort -> DONE, count_o=5.
4. Arm, 3 events, then abort_i and arm_i asserted together with valid_i=1 -> DONE, count_o=3. The concurrent event is not stored.
5. In DONE with 9 entries, toggle rd_ready_i randomly -> exactly 9 pops, no duplicates or gaps. arm_i then gives count_o=0 and state ARMED next edge.
6. Assert rst_i asynchronously mid-CAPTURE, between clock edges -> state_o=0, count_o=0, overflow_o=0, rd_valid_o=0 immediately. No recording while in IDLE afterwards.

Source files
------------

// File: rtl/riscv_trace_buffer_if.sv
// Read-side port of the retirement trace buffer.
// Member names are given from the buffer's point of view.
interface riscv_trace_buffer_if #(
   parameter int unsigned DW   = 32,
   parameter int unsigned REGW = 5
);
   logic            rd_valid_o;
   logic            rd_ready_i;
   logic [DW-1:0]   rd_pc_o;
   logic [DW-1:0]   rd_instr_o;
   logic [REGW-1:0] rd_rd_o;
   logic            rd_we_o;

   modport master (
      output rd_valid_o, rd_pc_o, rd_instr_o, rd_rd_o, rd_we_o,
      input  rd_ready_i
   );

   modport slave (
      input  rd_valid_o, rd_pc_o, rd_instr_o, rd_rd_o, rd_we_o,
      output rd_ready_i
   );
endinterface

// File: rtl/riscv_trace_buffer.sv
// Retirement-trace capture: circular buffer of retired instructions with arm,
// PC-match trigger and post-trigger window, then frozen and drained over valid/ready.
module riscv_trace_buffer #(
   parameter int unsigned DW         = 32,
   parameter int unsigned REGW       = 5,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned PTRW       = $clog2(DEPTH),
   parameter int unsigned POST_TRIG  = 8,
   parameter bit          RECORD_ALL = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   input  logic [DW-1:0]      pc_i,
   input  logic [DW-1:0]      instr_i,
   input  logic [REGW-1:0]    rd_i,
   input  logic               reg_write_i,
   input  logic               arm_i,
   input  logic               abort_i,
   input  logic               trig_en_i,
   input  logic [DW-1:0]      trig_pc_i,
   riscv_trace_buffer_if.master rd_if,
   output logic [PTRW:0]      count_o,
   output logic [1:0]         state_o,
   output logic               overflow_o
);

   localparam int unsigned CW = PTRW + 1;
   localparam int unsigned EW = 2*DW + REGW + 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [PTRW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [PTRW-1:0] post_q, post_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic            mem_we, clear, pop, rec_ev, trig, rd_valid;
   logic [EW-1:0]   mem [DEPTH];
   logic [EW-1:0]   rd_entry;

   assign rec_ev   = valid_i && (RECORD_ALL || reg_write_i);
   assign trig     = !trig_en_i || (pc_i == trig_pc_i);
   assign rd_valid = (state_q == S_DONE) && (cnt_q != '0);

   // Next-state, pointer and counter logic
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      post_d  = post_q;
      mem_we  = 1'b0;
      clear   = 1'b0;
      pop     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (arm_i) begin
               clear   = 1'b1;
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (abort_i) begin
               state_d = S_DONE;
            end else if (rec_ev) begin
               mem_we = 1'b1;
               if (trig) begin
                  post_d  = PTRW'(POST_TRIG);
                  state_d = (POST_TRIG == 0) ? S_DONE : S_CAPTURE;
               end
            end
         end
         S_CAPTURE: begin
            if (abort_i) begin
               state_d = S_DONE;
            end else if (rec_ev) begin
               mem_we = 1'b1;
               post_d = post_q - PTRW'(1);
               if (post_q == PTRW'(1)) state_d = S_DONE;
            end
         end
         default: begin
            // abort in DONE only re-freezes, so it masks a concurrent arm
            if (arm_i && !abort_i) begin
               clear   = 1'b1;
               state_d = S_ARMED;
            end else if (rd_valid && rd_if.rd_ready_i) begin
               pop = 1'b1;
            end
         end
      endcase

      if (clear) begin
         wr_d   = '0;
         rd_d   = '0;
         cnt_d  = '0;
         ovf_d  = 1'b0;
         post_d = '0;
      end
      if (mem_we) begin
         wr_d = wr_q + PTRW'(1);
         if (cnt_q == CW'(DEPTH)) begin
            rd_d  = rd_q + PTRW'(1);
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      if (pop) begin
         rd_d  = rd_q + PTRW'(1);
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         post_q  <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         post_q  <= post_d;
      end
   end

   // Trace storage, intentionally not reset
   always_ff @(posedge clk_i) begin
      if (mem_we) mem[wr_q] <= {pc_i, instr_i, rd_i, reg_write_i};
   end

   assign rd_entry = mem[rd_q];

   always_comb begin
      rd_if.rd_valid_o = rd_valid;
      rd_if.rd_pc_o    = '0;
      rd_if.rd_instr_o = '0;
      rd_if.rd_rd_o    = '0;
      rd_if.rd_we_o    = 1'b0;
      if (rd_valid) begin
         rd_if.rd_pc_o    = rd_entry[EW-1 -: DW];
         rd_if.rd_instr_o = rd_entry[EW-DW-1 -: DW];
         rd_if.rd_rd_o    = rd_entry[REGW:1];
         rd_if.rd_we_o    = rd_entry[0];
      end
   end

   assign count_o    = cnt_q;
   assign state_o    = state_q;
   assign overflow_o = ovf_q;

endmodule
